// File: rtl/vau_pkg.sv
// Shared types for the vector accelerator job scheduler.
//   vau_state_t : sequencer states
//   vau_job_t   : one queued job (opcode, element count, source/destination base)
//   VAU_OP_*    : opcode values understood by the vector datapath
package vau_pkg;

    // Width of the address fields carried in a queued job. The scheduler's
    // ADDR_W parameter defaults to this value; the ports are cast to and from it.
    localparam int JOB_ADDR_W = 10;

    localparam logic [3:0] VAU_OP_NOP  = 4'd0;
    localparam logic [3:0] VAU_OP_COPY = 4'd1;
    localparam logic [3:0] VAU_OP_ADD  = 4'd2;
    localparam logic [3:0] VAU_OP_MUL  = 4'd3;
    localparam logic [3:0] VAU_OP_MAC  = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_ERROR
    } vau_state_t;

    typedef struct packed {
        logic [3:0]            op;
        logic [7:0]            len;
        logic [JOB_ADDR_W-1:0] src;
        logic [JOB_ADDR_W-1:0] dst;
    } vau_job_t;

endpackage

// File: rtl/vau_job_fifo.sv
// Job queue for the scheduler: DEPTH entries of vau_job_t, count-based
// full/empty, show-ahead read (rdata is always the head entry).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wdata     write request and job to store (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   flush           empty the queue; a push in the same cycle survives
//   rdata           head entry
//   full, empty     occupancy flags
module vau_job_fifo
    import vau_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  vau_job_t wdata,
    input  logic     pop,
    input  logic     flush,
    output vau_job_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    vau_job_t         mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Restart at slot 0; a simultaneous push lands there.
            rd_ptr <= '0;
            wr_ptr <= push_ok ? PTR_W'(1) : '0;
            count  <= push_ok ? (PTR_W+1)'(1) : '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[flush ? '0 : wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vau_job_scheduler.sv
// Command queue and sequencer for the vector accelerator unit. The management
// SoC pushes jobs; they are issued one at a time to the vector datapath and the
// block waits for done/error/timeout. busy_flag is high for exactly the duration
// of a job batch and cyc_count records that duration in cycles.
// Ports:
//   wb_clk_i, wb_rst_i             clock, synchronous active-high reset
//   cmd_valid/cmd_ready            job push handshake (ready = queue not full)
//   cmd_op/len/src/dst             job fields (len 0 = null job, never started)
//   abort                          flush queue and cancel the current job
//   vu_start                       one-cycle start pulse to the datapath
//   vu_op/len/src/dst              current job fields, held until the next issue
//   vu_done, vu_err                datapath completion pulse and error qualifier
//   busy_flag                      batch in progress (to mprj_io[20])
//   cyc_count                      busy cycles of the current/last batch (saturating)
//   jobs_done                      jobs completed without error (wraps)
//   err_flag                       sticky error, cleared by the next accepted push
//   irq                            one-cycle pulse at the end of every batch
module vau_job_scheduler
    import vau_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = JOB_ADDR_W,
    parameter int TIMEOUT = 65535
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [7:0]        cmd_len,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic              abort,
    output logic              vu_start,
    output logic [3:0]        vu_op,
    output logic [7:0]        vu_len,
    output logic [ADDR_W-1:0] vu_src,
    output logic [ADDR_W-1:0] vu_dst,
    input  logic              vu_done,
    input  logic              vu_err,
    output logic              busy_flag,
    output logic [31:0]       cyc_count,
    output logic [7:0]        jobs_done,
    output logic              err_flag,
    output logic              irq
);

    vau_state_t state;
    vau_state_t state_nx;
    vau_job_t   cmd_job;
    vau_job_t   head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push_acc;
    logic       pop;
    logic       flush;
    logic       tmo_hit;
    logic [31:0] tmo_cnt;

    // A push coinciding with abort is dropped.
    assign cmd_ready = !fifo_full;
    assign push_acc  = cmd_valid && !fifo_full && !abort;
    assign pop       = (state == ST_ISSUE) && !abort;
    assign flush     = abort || (state == ST_ERROR);
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt <= 32'd1);

    always_comb begin
        cmd_job     = '0;
        cmd_job.op  = cmd_op;
        cmd_job.len = cmd_len;
        cmd_job.src = JOB_ADDR_W'(cmd_src);
        cmd_job.dst = JOB_ADDR_W'(cmd_dst);
    end

    vau_job_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push_acc),
        .wdata (cmd_job),
        .pop   (pop),
        .flush (flush),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (!fifo_empty) state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = (head.len == 8'd0) ? ST_NEXT : ST_WAIT;
            ST_WAIT: begin
                if (vu_done)
                    state_nx = vu_err ? ST_ERROR : ST_NEXT;
                else if (tmo_hit)
                    state_nx = ST_ERROR;
            end
            ST_NEXT:  state_nx = fifo_empty ? ST_IDLE : ST_ISSUE;
            ST_ERROR: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (abort)
            state_nx = ST_IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            busy_flag <= 1'b0;
            irq       <= 1'b0;
            cyc_count <= '0;
            jobs_done <= '0;
            err_flag  <= 1'b0;
            tmo_cnt   <= '0;
            vu_start  <= 1'b0;
            vu_op     <= '0;
            vu_len    <= '0;
            vu_src    <= '0;
            vu_dst    <= '0;
        end else begin
            state     <= state_nx;
            busy_flag <= (state_nx != ST_IDLE);
            // Every return to IDLE from a busy state ends a batch.
            irq       <= (state != ST_IDLE) && (state_nx == ST_IDLE);

            if (!busy_flag && (state_nx != ST_IDLE))
                cyc_count <= '0;
            else if (busy_flag && (cyc_count != '1))
                cyc_count <= cyc_count + 32'd1;

            if (!abort && (((state == ST_WAIT) && vu_done && !vu_err) ||
                           ((state == ST_ISSUE) && (head.len == 8'd0))))
                jobs_done <= jobs_done + 8'd1;

            if ((state == ST_ERROR) && !abort)
                err_flag <= 1'b1;
            else if (push_acc)
                err_flag <= 1'b0;

            if (pop)
                tmo_cnt <= 32'(TIMEOUT);
            else if ((state == ST_WAIT) && (tmo_cnt != '0))
                tmo_cnt <= tmo_cnt - 32'd1;

            // Null jobs are popped and counted but never reach the datapath.
            vu_start <= pop && (head.len != 8'd0);
            if (abort) begin
                vu_op  <= '0;
                vu_len <= '0;
                vu_src <= '0;
                vu_dst <= '0;
            end else if (pop) begin
                vu_op  <= head.op;
                vu_len <= head.len;
                vu_src <= ADDR_W'(head.src);
                vu_dst <= ADDR_W'(head.dst);
            end
        end
    end

endmodule

// File: tb/tb_vau_job_scheduler.sv
module tb_vau_job_scheduler;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [7:0]  cmd_len = '0;
    logic [9:0]  cmd_src = '0;
    logic [9:0]  cmd_dst = '0;
    logic        abort = 1'b0;
    logic        vu_start;
    logic [3:0]  vu_op;
    logic [7:0]  vu_len;
    logic [9:0]  vu_src;
    logic [9:0]  vu_dst;
    logic        vu_done = 1'b0;
    logic        vu_err = 1'b0;
    logic        busy_flag;
    logic [31:0] cyc_count;
    logic [7:0]  jobs_done;
    logic        err_flag;
    logic        irq;

    int total = 0;
    int bad = 0;
    int irq_cnt = 0;
    int start_cnt = 0;
    int drop_cnt = 0;
    int base_irq, base_start, base_drop;

    vau_job_scheduler #(.DEPTH(4), .ADDR_W(10), .TIMEOUT(100)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .abort     (abort),
        .vu_start  (vu_start),
        .vu_op     (vu_op),
        .vu_len    (vu_len),
        .vu_src    (vu_src),
        .vu_dst    (vu_dst),
        .vu_done   (vu_done),
        .vu_err    (vu_err),
        .busy_flag (busy_flag),
        .cyc_count (cyc_count),
        .jobs_done (jobs_done),
        .err_flag  (err_flag),
        .irq       (irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and tally the sampled pulse outputs.
    task automatic step();
        @(negedge wb_clk_i);
        if (irq)        irq_cnt++;
        if (vu_start)   start_cnt++;
        if (!busy_flag) drop_cnt++;
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] len,
                        input logic [9:0] src, input logic [9:0] dst);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_src   = src;
        cmd_dst   = dst;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!vu_start && n < 200) begin
            step();
            n++;
        end
        check(tag, vu_start, 1'b1);
    endtask

    // Called in the vu_start cycle; vu_done arrives 'gap' cycles later.
    task automatic finish_job(input int gap, input logic err);
        repeat (gap) step();
        vu_done = 1'b1;
        vu_err  = err;
        step();
        vu_done = 1'b0;
        vu_err  = 1'b0;
    endtask

    task automatic do_reset();
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        vu_done   = 1'b0;
        vu_err    = 1'b0;
        step();
        step();
        wb_rst_i = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst cmd_ready", cmd_ready, 1);
        check("rst busy", busy_flag, 0);
        check("rst vu_start", vu_start, 0);
        check("rst cyc_count", cyc_count, 0);
        check("rst jobs_done", jobs_done, 0);
        check("rst err_flag", err_flag, 0);
        check("rst irq", irq, 0);
        wb_rst_i = 1'b0;

        // Single job, done 20 cycles after start: 23 busy cycles
        base_irq = irq_cnt;
        push(4'd2, 8'd8, 10'h010, 10'h100);
        check("t1 no early start", vu_start, 0);
        step();
        check("t1 busy in issue", busy_flag, 1);
        check("t1 start not yet", vu_start, 0);
        step();
        check("t1 start latency", vu_start, 1);
        check("t1 vu_op", vu_op, 4'd2);
        check("t1 vu_len", vu_len, 8'd8);
        check("t1 vu_src", vu_src, 10'h010);
        check("t1 vu_dst", vu_dst, 10'h100);
        finish_job(20, 1'b0);
        check("t1 busy in next", busy_flag, 1);
        check("t1 jobs_done", jobs_done, 1);
        step();
        check("t1 busy fell", busy_flag, 0);
        check("t1 irq", irq, 1);
        check("t1 cyc_count", cyc_count, 23);
        step();
        check("t1 irq pulses", irq_cnt - base_irq, 1);
        check("t1 cyc_count holds", cyc_count, 23);

        // Queue full: one job in flight plus four queued
        do_reset();
        push(4'd1, 8'd2, 10'h001, 10'h101);
        wait_start("t2 lead start");
        for (int i = 0; i < 4; i++) begin
            check("t2 ready before push", cmd_ready, 1);
            push(4'(i + 4), 8'd3, 10'(i + 16), 10'(i + 32));
        end
        check("t2 full", cmd_ready, 0);
        push(4'd15, 8'd3, 10'h3FF, 10'h3FF);
        base_irq  = irq_cnt;
        base_drop = drop_cnt;
        finish_job(2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_start("t2 queued start");
            check("t2 order op", vu_op, 4'(i + 4));
            check("t2 order src", vu_src, 10'(i + 16));
            finish_job(2, 1'b0);
        end
        check("t2 busy never dropped", drop_cnt - base_drop, 0);
        check("t2 no irq mid batch", irq_cnt - base_irq, 0);
        base_start = start_cnt;
        step();
        check("t2 end irq", irq, 1);
        check("t2 jobs_done", jobs_done, 5);
        repeat (4) step();
        check("t2 full push dropped", start_cnt - base_start, 0);

        // Datapath error on job 2 of 3
        do_reset();
        push(4'd1, 8'd4, 10'h001, 10'h002);
        push(4'd2, 8'd4, 10'h003, 10'h004);
        push(4'd3, 8'd4, 10'h005, 10'h006);
        wait_start("t3 job1 start");
        check("t3 job1 op", vu_op, 1);
        finish_job(3, 1'b0);
        wait_start("t3 job2 start");
        check("t3 job2 op", vu_op, 2);
        finish_job(3, 1'b1);
        step();
        check("t3 err_flag", err_flag, 1);
        check("t3 irq", irq, 1);
        check("t3 busy", busy_flag, 0);
        check("t3 jobs_done", jobs_done, 1);
        base_start = start_cnt;
        repeat (5) step();
        check("t3 job3 flushed", start_cnt - base_start, 0);
        check("t3 err sticky", err_flag, 1);
        push(4'd4, 8'd0, 10'h000, 10'h000);
        check("t3 err cleared by push", err_flag, 0);

        // Timeout with no vu_done
        do_reset();
        push(4'd3, 8'd16, 10'h020, 10'h040);
        wait_start("t4 start");
        repeat (99) step();
        check("t4 still busy", busy_flag, 1);
        check("t4 no error yet", err_flag, 0);
        step();
        check("t4 busy in error", busy_flag, 1);
        step();
        check("t4 busy low", busy_flag, 0);
        check("t4 err_flag", err_flag, 1);
        check("t4 irq", irq, 1);
        check("t4 jobs_done", jobs_done, 0);

        // Abort mid-WAIT with two jobs queued
        do_reset();
        push(4'd1, 8'd4, 10'h011, 10'h012);
        push(4'd2, 8'd4, 10'h013, 10'h014);
        push(4'd3, 8'd4, 10'h015, 10'h016);
        wait_start("t5 start");
        repeat (3) step();
        base_irq  = irq_cnt;
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 4'd9;
        cmd_len   = 8'd4;
        step();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        check("t5 busy low", busy_flag, 0);
        check("t5 irq", irq, 1);
        check("t5 ready", cmd_ready, 1);
        check("t5 vu_op cleared", vu_op, 0);
        check("t5 vu_src cleared", vu_src, 0);
        check("t5 err unchanged", err_flag, 0);
        base_start = start_cnt;
        vu_done = 1'b1;
        step();
        vu_done = 1'b0;
        check("t5 late done ignored", jobs_done, 0);
        repeat (5) step();
        check("t5 queue empty", start_cnt - base_start, 0);
        check("t5 single irq", irq_cnt - base_irq, 1);
        check("t5 stays idle", busy_flag, 0);

        // Null job between two len=4 jobs
        do_reset();
        base_start = start_cnt;
        push(4'd5, 8'd4, 10'h001, 10'h002);
        push(4'd6, 8'd0, 10'h003, 10'h004);
        push(4'd7, 8'd4, 10'h005, 10'h006);
        wait_start("t6 first start");
        check("t6 first op", vu_op, 5);
        finish_job(2, 1'b0);
        wait_start("t6 second start");
        check("t6 null skipped", vu_op, 7);
        check("t6 second len", vu_len, 4);
        finish_job(2, 1'b0);
        check("t6 start pulses", start_cnt - base_start, 2);
        step();
        check("t6 irq", irq, 1);
        check("t6 jobs_done", jobs_done, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
